// File: rtl/fu_issue_arbiter.sv
// fu_issue_arbiter: dual-slot in-order issue arbiter for the add unit, the address
// unit and a non-pipelined multi-cycle multiplier.
// Optional feature macro: ISSUE_STATS_EN adds a saturating stall counter output.
module fu_issue_arbiter #(
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned TAG_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_vld_in,
    input  logic             req0_add_in,
    input  logic             req0_mult_in,
    input  logic             req0_addr_in,
    input  logic [TAG_W-1:0] req0_tag_in,
    input  logic             req1_vld_in,
    input  logic             req1_add_in,
    input  logic             req1_mult_in,
    input  logic             req1_addr_in,
    input  logic [TAG_W-1:0] req1_tag_in,
    input  logic             flush_in,
    output logic             gnt0_out,
    output logic             gnt1_out,
    output logic             add_vld_out,
    output logic [TAG_W-1:0] add_tag_out,
    output logic             addr_vld_out,
    output logic [TAG_W-1:0] addr_tag_out,
    output logic             mult_vld_out,
    output logic [TAG_W-1:0] mult_tag_out,
    output logic             mult_busy_out,
    output logic             mult_done_vld_out,
    output logic [TAG_W-1:0] mult_done_tag_out,
    output logic             req_err_out
`ifdef ISSUE_STATS_EN
    ,
    output logic [15:0]      stall_cnt_out
`endif
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mult_state_e;

    mult_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TAG_W-1:0] mtag_q, mtag_d;
    logic             done_d;

    logic             legal0, legal1;
    logic             mult_free, same_unit;
    logic             g0, g1;
    logic             add_issue, addr_issue, mult_gnt;
    logic [TAG_W-1:0] add_tag, addr_tag, mult_gnt_tag;
    logic             req_err;

    // A request is legal only when valid with exactly one unit selected
    assign legal0 = req0_vld_in && $onehot({req0_add_in, req0_mult_in, req0_addr_in});
    assign legal1 = req1_vld_in && $onehot({req1_add_in, req1_mult_in, req1_addr_in});
    assign req_err = (req0_vld_in && !$onehot({req0_add_in, req0_mult_in, req0_addr_in})) ||
                     (req1_vld_in && !$onehot({req1_add_in, req1_mult_in, req1_addr_in}));

    // Multiplier accepts a new op when idle or on its final busy cycle
    assign mult_free = (state_q == IDLE) || (cnt_q == CNT_ONE);
    assign same_unit = (req0_add_in  && req1_add_in)  ||
                       (req0_mult_in && req1_mult_in) ||
                       (req0_addr_in && req1_addr_in);

    // Same-cycle grants: slot 0 first, slot 1 only behind a granted or empty slot 0
    assign g0 = !rst && !flush_in && legal0 && (!req0_mult_in || mult_free);
    assign g1 = !rst && !flush_in && legal1 && (g0 || !req0_vld_in) &&
                !(g0 && same_unit) && (!req1_mult_in || mult_free);
    assign gnt0_out = g0;
    assign gnt1_out = g1;

    // Per-unit issue selection from the granted slots
    assign add_issue    = (g0 && req0_add_in)  || (g1 && req1_add_in);
    assign add_tag      = (g0 && req0_add_in)  ? req0_tag_in : req1_tag_in;
    assign addr_issue   = (g0 && req0_addr_in) || (g1 && req1_addr_in);
    assign addr_tag     = (g0 && req0_addr_in) ? req0_tag_in : req1_tag_in;
    assign mult_gnt     = (g0 && req0_mult_in) || (g1 && req1_mult_in);
    assign mult_gnt_tag = (g0 && req0_mult_in) ? req0_tag_in : req1_tag_in;

    assign mult_busy_out = (state_q == BUSY);

    // Multiplier sequencing: next state, occupancy count, tag latch and done strobe
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mtag_d  = mtag_q;
        done_d  = 1'b0;
        if (flush_in) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mult_gnt) begin
                        state_d = BUSY;
                        cnt_d   = CNT_LOAD;
                        mtag_d  = mult_gnt_tag;
                    end
                end
                BUSY: begin
                    if (cnt_q == CNT_ONE) begin
                        done_d = 1'b1;
                        if (mult_gnt) begin
                            cnt_d  = CNT_LOAD;
                            mtag_d = mult_gnt_tag;
                        end else begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and registered issue/done/error outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q           <= IDLE;
            cnt_q             <= '0;
            mtag_q            <= '0;
            add_vld_out       <= 1'b0;
            add_tag_out       <= '0;
            addr_vld_out      <= 1'b0;
            addr_tag_out      <= '0;
            mult_vld_out      <= 1'b0;
            mult_tag_out      <= '0;
            mult_done_vld_out <= 1'b0;
            mult_done_tag_out <= '0;
            req_err_out       <= 1'b0;
        end else begin
            state_q           <= state_d;
            cnt_q             <= cnt_d;
            mtag_q            <= mtag_d;
            add_vld_out       <= add_issue;
            add_tag_out       <= add_issue ? add_tag : '0;
            addr_vld_out      <= addr_issue;
            addr_tag_out      <= addr_issue ? addr_tag : '0;
            mult_vld_out      <= mult_gnt;
            mult_tag_out      <= mult_gnt ? mult_gnt_tag : '0;
            mult_done_vld_out <= done_d;
            mult_done_tag_out <= done_d ? mtag_q : '0;
            req_err_out       <= req_err;
        end
    end

`ifdef ISSUE_STATS_EN
    logic stall_evt;
    assign stall_evt = !flush_in && ((legal0 && !g0) || (legal1 && !g1));

    // Saturating count of cycles with a legal request left waiting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_out <= '0;
        end else if (stall_evt && (stall_cnt_out != 16'hFFFF)) begin
            stall_cnt_out <= stall_cnt_out + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fu_issue_arbiter.sv
// tb_fu_issue_arbiter: directed stimulus with a cycle-level reference model.
module tb_fu_issue_arbiter;

    localparam int unsigned MUL_LAT = 3;
    localparam int unsigned TAG_W   = 4;

    logic clk = 1'b0;
    logic rst;
    logic v0, a0, m0, r0, v1, a1, m1, r1, flush;
    logic [TAG_W-1:0] t0, t1;
    logic gnt0, gnt1, add_vld, addr_vld, mult_vld, busy, done_vld, err;
    logic [TAG_W-1:0] add_tag, addr_tag, mult_tag, done_tag;
`ifdef ISSUE_STATS_EN
    logic [15:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    fu_issue_arbiter #(.MUL_LAT(MUL_LAT), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .req0_vld_in(v0), .req0_add_in(a0), .req0_mult_in(m0), .req0_addr_in(r0), .req0_tag_in(t0),
        .req1_vld_in(v1), .req1_add_in(a1), .req1_mult_in(m1), .req1_addr_in(r1), .req1_tag_in(t1),
        .flush_in(flush),
        .gnt0_out(gnt0), .gnt1_out(gnt1),
        .add_vld_out(add_vld), .add_tag_out(add_tag),
        .addr_vld_out(addr_vld), .addr_tag_out(addr_tag),
        .mult_vld_out(mult_vld), .mult_tag_out(mult_tag),
        .mult_busy_out(busy),
        .mult_done_vld_out(done_vld), .mult_done_tag_out(done_tag),
        .req_err_out(err)
`ifdef ISSUE_STATS_EN
        , .stall_cnt_out(stall_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    // Reference model state: pending completions and multiplier availability in cycles
    typedef struct {
        int               due;
        logic [TAG_W-1:0] tag;
    } pend_t;
    pend_t pend_q[$];
    int next_ok = 0, last_g = -100, busy_until = -100;
    logic e_add, e_addr, e_mult, e_done, e_busy, e_err;
    logic [TAG_W-1:0] e_add_tag, e_addr_tag, e_mult_tag, e_done_tag;
    logic [15:0] e_stall;

    initial begin
        e_add = 0; e_addr = 0; e_mult = 0; e_done = 0; e_busy = 0; e_err = 0;
        e_add_tag = 0; e_addr_tag = 0; e_mult_tag = 0; e_done_tag = 0; e_stall = 0;
    end

    // Compare DUT against the model mid-cycle, then advance the model across the next edge
    always @(negedge clk) begin : cmp
        bit l0, l1, x_g0, x_g1, mfree;
        int u0, u1;
        if (rst) begin
            chk("rst_gnt0", gnt0, 0);       chk("rst_gnt1", gnt1, 0);
            chk("rst_add_vld", add_vld, 0); chk("rst_addr_vld", addr_vld, 0);
            chk("rst_mult_vld", mult_vld, 0); chk("rst_busy", busy, 0);
            chk("rst_done", done_vld, 0);   chk("rst_err", err, 0);
            chk("rst_tags", {add_tag, addr_tag, mult_tag, done_tag}, 0);
`ifdef ISSUE_STATS_EN
            chk("rst_stall", stall_cnt, 0);
`endif
            pend_q.delete();
            next_ok = cyc + 1; last_g = -100; busy_until = -100;
            e_add = 0; e_addr = 0; e_mult = 0; e_done = 0; e_busy = 0; e_err = 0;
            e_stall = 0;
        end else begin
            chk("add_vld", add_vld, e_add);
            if (e_add) chk("add_tag", add_tag, e_add_tag);
            chk("addr_vld", addr_vld, e_addr);
            if (e_addr) chk("addr_tag", addr_tag, e_addr_tag);
            chk("mult_vld", mult_vld, e_mult);
            if (e_mult) chk("mult_tag", mult_tag, e_mult_tag);
            chk("mult_busy", busy, e_busy);
            chk("done_vld", done_vld, e_done);
            if (e_done) chk("done_tag", done_tag, e_done_tag);
            chk("req_err", err, e_err);
`ifdef ISSUE_STATS_EN
            chk("stall_cnt", stall_cnt, e_stall);
`endif
            l0 = v0 && ($countones({a0, m0, r0}) == 1);
            l1 = v1 && ($countones({a1, m1, r1}) == 1);
            u0 = a0 ? 0 : (m0 ? 1 : 2);
            u1 = a1 ? 0 : (m1 ? 1 : 2);
            mfree = (cyc >= next_ok);
            x_g0 = !flush && l0 && (u0 != 1 || mfree);
            x_g1 = !flush && l1 && (x_g0 || !v0) && !(x_g0 && u0 == u1) && (u1 != 1 || mfree);
            chk("gnt0", gnt0, x_g0);
            chk("gnt1", gnt1, x_g1);

            e_add  = (x_g0 && u0 == 0) || (x_g1 && u1 == 0);
            e_add_tag  = (x_g0 && u0 == 0) ? t0 : t1;
            e_addr = (x_g0 && u0 == 2) || (x_g1 && u1 == 2);
            e_addr_tag = (x_g0 && u0 == 2) ? t0 : t1;
            e_mult = (x_g0 && u0 == 1) || (x_g1 && u1 == 1);
            e_mult_tag = (x_g0 && u0 == 1) ? t0 : t1;
            e_err  = (v0 && !l0) || (v1 && !l1);
            e_done = 0;
            if (flush) begin
                pend_q.delete();
                next_ok = cyc + 1;
                busy_until = cyc;
            end else begin
                if (pend_q.size() > 0 && pend_q[0].due == cyc + 1) begin
                    e_done = 1;
                    e_done_tag = pend_q[0].tag;
                    void'(pend_q.pop_front());
                end
                if (e_mult) begin
                    pend_q.push_back('{due: cyc + MUL_LAT, tag: e_mult_tag});
                    next_ok = cyc + MUL_LAT - 1;
                    last_g = cyc;
                    busy_until = cyc + MUL_LAT - 1;
                end
                if (((l0 && !x_g0) || (l1 && !x_g1)) && e_stall != 16'hFFFF)
                    e_stall = e_stall + 16'd1;
            end
            e_busy = (cyc + 1 > last_g) && (cyc + 1 <= busy_until);
        end
        cyc++;
    end

    // Apply one cycle of inputs just after the rising edge
    task automatic cyc_in(input logic iv0, ia0, im0, ir0, input int it0,
                          input logic iv1, ia1, im1, ir1, input int it1, input logic ifl);
        @(posedge clk); #1;
        v0 = iv0; a0 = ia0; m0 = im0; r0 = ir0; t0 = TAG_W'(it0);
        v1 = iv1; a1 = ia1; m1 = im1; r1 = ir1; t1 = TAG_W'(it1);
        flush = ifl;
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc_in(0,0,0,0,0, 0,0,0,0,0, 0);
    endtask

    initial begin
        rst = 1'b1;
        v0 = 0; a0 = 0; m0 = 0; r0 = 0; t0 = 0;
        v1 = 0; a1 = 0; m1 = 0; r1 = 0; t1 = 0; flush = 0;
        repeat (2) @(posedge clk);
        #3;
        chk("lit_reset_add_vld", add_vld, 0);
        chk("lit_reset_busy", busy, 0);
        @(posedge clk); #1; rst = 1'b0;
        idle(2);

        // add + add: slot 1 stalls, tags issue in order
        cyc_in(1,1,0,0,1, 1,1,0,0,2, 0);
        chk("lit1_gnt0", gnt0, 1); chk("lit1_gnt1", gnt1, 0);
        cyc_in(1,1,0,0,2, 0,0,0,0,0, 0);
        chk("lit1_add_vld_c1", add_vld, 1); chk("lit1_add_tag_c1", add_tag, 1);
        cyc_in(0,0,0,0,0, 0,0,0,0,0, 0);
        chk("lit1_add_tag_c2", add_tag, 2);
        idle(3);

        // mult + addr both granted, done at MUL_LAT
        cyc_in(1,0,1,0,3, 1,0,0,1,4, 0);
        chk("lit2_gnt0", gnt0, 1); chk("lit2_gnt1", gnt1, 1);
        cyc_in(0,0,0,0,0, 0,0,0,0,0, 0);
        chk("lit2_mult_vld", mult_vld, 1); chk("lit2_addr_tag", addr_tag, 4);
        chk("lit2_busy_c1", busy, 1);
        cyc_in(0,0,0,0,0, 0,0,0,0,0, 0);
        chk("lit2_busy_c2", busy, 1);
        cyc_in(0,0,0,0,0, 0,0,0,0,0, 0);
        chk("lit2_done", done_vld, 1); chk("lit2_done_tag", done_tag, 3);
        chk("lit2_busy_c3", busy, 0);
        idle(2);

        // back-to-back multiplies
        cyc_in(1,0,1,0,5, 0,0,0,0,0, 0);
        cyc_in(1,0,1,0,6, 0,0,0,0,0, 0);
        chk("lit3_gnt_c1", gnt0, 0);
        cyc_in(1,0,1,0,6, 0,0,0,0,0, 0);
        chk("lit3_gnt_c2", gnt0, 1);
        cyc_in(0,0,0,0,0, 0,0,0,0,0, 0);
        chk("lit3_done5_tag", done_tag, 5); chk("lit3_busy_c3", busy, 1);
        cyc_in(0,0,0,0,0, 0,0,0,0,0, 0);
        chk("lit3_busy_c4", busy, 1);
        cyc_in(0,0,0,0,0, 0,0,0,0,0, 0);
        chk("lit3_done6_tag", done_tag, 6); chk("lit3_busy_c5", busy, 0);
        idle(2);

        // flush aborts an in-flight multiply
        cyc_in(1,0,1,0,7, 0,0,0,0,0, 0);
        cyc_in(1,0,1,0,8, 1,1,0,0,9, 1);
        chk("lit4_gnt0_flush", gnt0, 0); chk("lit4_gnt1_flush", gnt1, 0);
        cyc_in(1,0,1,0,8, 0,0,0,0,0, 0);
        chk("lit4_busy_c2", busy, 0); chk("lit4_gnt0_c2", gnt0, 1);
        cyc_in(0,0,0,0,0, 0,0,0,0,0, 0);
        chk("lit4_no_done_c3", done_vld, 0);
        idle(4);

        // flush on the same edge a done would be produced
        cyc_in(1,0,1,0,12, 0,0,0,0,0, 0);
        cyc_in(0,0,0,0,0, 0,0,0,0,0, 0);
        cyc_in(0,0,0,0,0, 0,0,0,0,0, 1);
        cyc_in(0,0,0,0,0, 0,0,0,0,0, 0);
        chk("lit_flush_done", done_vld, 0);
        idle(2);

        // illegal slot 0 blocks slot 1 and raises an error
        cyc_in(1,1,1,0,9, 1,1,0,0,10, 0);
        chk("lit5_gnt0", gnt0, 0); chk("lit5_gnt1", gnt1, 0);
        cyc_in(0,0,0,0,0, 0,0,0,0,0, 0);
        chk("lit5_err", err, 1);
        idle(2);

        // misc pairings
        cyc_in(0,0,0,0,0, 1,1,0,0,13, 0);
        chk("lit_empty0_gnt1", gnt1, 1);
        cyc_in(1,1,0,0,1, 1,0,0,1,2, 0);
        chk("lit_add_addr_gnt1", gnt1, 1);
        cyc_in(1,0,0,1,3, 1,0,0,1,4, 0);
        chk("lit_addr_addr_gnt1", gnt1, 0);
        cyc_in(1,0,1,0,14, 0,0,0,0,0, 0);
        cyc_in(1,1,0,0,1, 1,0,1,0,2, 0);
        chk("lit_mult_busy_gnt1", gnt1, 0);
        cyc_in(1,0,0,0,5, 0,0,0,0,0, 0);
        idle(4);

        // reset mid-multiply
        cyc_in(1,0,1,0,11, 0,0,0,0,0, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        v0 = 0; m0 = 0; t0 = 0;
        #2;
        chk("lit6_mult_vld", mult_vld, 0); chk("lit6_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        idle(6);

        // model-checked sweep
        for (int i = 0; i < 80; i++) begin
            logic [2:0] f0, f1;
            int s0, s1;
            s0 = $urandom_range(0, 4); s1 = $urandom_range(0, 4);
            f0 = (s0 < 3) ? 3'(3'b001 << s0) : 3'($urandom_range(0, 7));
            f1 = (s1 < 3) ? 3'(3'b001 << s1) : 3'($urandom_range(0, 7));
            cyc_in(1'($urandom_range(0, 3) != 0), f0[2], f0[1], f0[0], $urandom_range(0, 15),
                   1'($urandom_range(0, 3) != 0), f1[2], f1[1], f1[0], $urandom_range(0, 15),
                   1'($urandom_range(0, 11) == 0));
        end
        idle(6);

        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
